// File: rtl/aes_pkg.sv
// Shared AES decryption constants: widths, stage FSM encoding and the inverse S-box table.
package aes_pkg;

  localparam int AES_STATE_W   = 128;
  localparam int AES_BYTE_W    = 8;
  localparam int AES_NUM_BYTES = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} fsm_state_t;

  // Counter width that stays at least one bit when only a single step exists.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready stream carrying one 128-bit AES state between round stages.
interface inv_sub_bytes_seq_if;
  import aes_pkg::*;

  logic                   valid;
  logic                   ready;
  logic [AES_STATE_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup for a single byte.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] data,
  output logic [AES_BYTE_W-1:0] result
);

  assign result = INV_SBOX[data];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes: substitutes BYTES_PER_CYCLE bytes per clock through shared S-boxes.
// Optional build macro INV_SUB_BYTES_PIPE_EN registers the S-box outputs and adds a DRAIN state.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  inv_sub_bytes_seq_if.slave   in_bus,
  inv_sub_bytes_seq_if.master  out_bus
);

  localparam int N_STEPS = AES_NUM_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W   = cnt_width(N_STEPS);
  localparam int STEP_W  = BYTES_PER_CYCLE * AES_BYTE_W;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  fsm_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [AES_STATE_W-1:0] data_reg, data_next;
  logic [STEP_W-1:0]      step_in, step_out;
  logic                   accept, release_out;
  logic                   wr_en;
  logic [CNT_W-1:0]       wr_idx;
  logic [STEP_W-1:0]      wr_data;

  assign in_bus.ready  = rst_n && (state_reg == IDLE);
  assign out_bus.valid = (state_reg == DONE);
  assign out_bus.data  = data_reg;
  assign accept        = in_bus.valid && in_bus.ready;
  assign release_out   = (state_reg == DONE) && out_bus.ready;

  assign step_in = data_reg[STEP_W*int'(cnt_reg) +: STEP_W];

  for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_sbox
    inv_sbox u_sbox (
      .data   (step_in[AES_BYTE_W*gi +: AES_BYTE_W]),
      .result (step_out[AES_BYTE_W*gi +: AES_BYTE_W])
    );
  end

`ifdef INV_SUB_BYTES_PIPE_EN
  // Each step's bytes land in the state register one clock after lookup.
  localparam fsm_state_t AFTER_BUSY = DRAIN;

  logic              pipe_vld_reg;
  logic [CNT_W-1:0]  pipe_idx_reg;
  logic [STEP_W-1:0] pipe_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_reg  <= 1'b0;
      pipe_idx_reg  <= '0;
      pipe_data_reg <= '0;
    end else begin
      pipe_vld_reg  <= (state_reg == BUSY);
      pipe_idx_reg  <= cnt_reg;
      pipe_data_reg <= step_out;
    end
  end

  assign wr_en   = pipe_vld_reg;
  assign wr_idx  = pipe_idx_reg;
  assign wr_data = pipe_data_reg;
`else
  localparam fsm_state_t AFTER_BUSY = DONE;

  assign wr_en   = (state_reg == BUSY);
  assign wr_idx  = cnt_reg;
  assign wr_data = step_out;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          cnt_next   = '0;
        end
      end
      BUSY: begin
        if (cnt_reg == LAST_STEP) begin
          state_next = AFTER_BUSY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DRAIN: state_next = DONE;
      DONE: begin
        if (release_out) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_next = data_reg;
    if (accept) begin
      data_next = in_bus.data;
    end else if (wr_en) begin
      data_next[STEP_W*int'(wr_idx) +: STEP_W] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
    end
  end

endmodule
